// File: rtl/instruction_sequencer.sv
// Initiator side of the 3-bit I/CR instruction interface: turns one host
// descriptor into the CR/address/word loads, counter init and per-word steps.
module instruction_sequencer #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_mode,
    input  logic [DW-1:0] cmd_addr,
    input  logic [CW-1:0] cmd_count,
    input  logic          abort,
    input  logic          xfer_req,
    output logic          xfer_ack,
    input  logic          tc,
    output logic [2:0]    I,
    output logic          inst_valid,
    output logic [2:0]    cr_data,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          tc_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDCR = 3'd1,
        S_LDAR = 3'd2,
        S_LDWR = 3'd3,
        S_INIT = 3'd4,
        S_WAIT = 3'd5,
        S_XFER = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          aborted_q, aborted_d;
    logic          tc_err_q, tc_err_d;

    logic [2:0]    i_q, i_d;
    logic          inst_valid_q, inst_valid_d;
    logic [2:0]    cr_data_q, cr_data_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d;
    logic          xfer_ack_q, xfer_ack_d;
    logic          done_q, done_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;

    logic          last_step_s;

    assign last_step_s = (rem_q == CW'(1));

    // Next-state logic, then output decode from the next state so outputs are
    // registered alongside the state they describe.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        count_d   = count_q;
        rem_d     = rem_q;
        aborted_d = aborted_q;
        tc_err_d  = tc_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d    = cmd_mode;
                    addr_d    = cmd_addr;
                    count_d   = cmd_count;
                    rem_d     = cmd_count;
                    aborted_d = 1'b0;
                    tc_err_d  = 1'b0;
                    state_d   = (cmd_count == {CW{1'b0}}) ? S_DONE : S_LDCR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LDCR: state_d = S_LDAR;
            S_LDAR: state_d = S_LDWR;
            S_LDWR: state_d = S_INIT;
            S_INIT: state_d = S_WAIT;
            S_WAIT: begin
                if (xfer_req) begin
                    state_d = S_XFER;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_XFER: begin
                rem_d = rem_q - CW'(1);
                // tc is only cross-checked; completion follows rem alone
                if (tc != last_step_s) begin
                    tc_err_d = 1'b1;
                end else begin
                    tc_err_d = tc_err_q;
                end
                state_d = last_step_s ? S_DONE : S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
        end else begin
            aborted_d = aborted_d;
        end

        i_d          = 3'b001;
        inst_valid_d = 1'b0;
        cr_data_d    = 3'b000;
        data_out_d   = {DW{1'b0}};
        data_oe_d    = 1'b0;
        xfer_ack_d   = 1'b0;
        done_d       = 1'b0;
        cmd_ready_d  = 1'b0;
        busy_d       = 1'b1;

        case (state_d)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            S_LDCR: begin
                i_d          = 3'b000;
                inst_valid_d = 1'b1;
                cr_data_d    = mode_d;
            end
            S_LDAR: begin
                i_d          = 3'b101;
                inst_valid_d = 1'b1;
                data_out_d   = addr_d;
                data_oe_d    = 1'b1;
            end
            S_LDWR: begin
                i_d          = 3'b110;
                inst_valid_d = 1'b1;
                data_out_d   = DW'(count_d);
                data_oe_d    = 1'b1;
            end
            S_INIT: begin
                i_d          = 3'b100;
                inst_valid_d = 1'b1;
            end
            S_WAIT: begin
                i_d = 3'b001;
            end
            S_XFER: begin
                i_d          = 3'b111;
                inst_valid_d = 1'b1;
                xfer_ack_d   = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, descriptor and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 3'b000;
            addr_q       <= {DW{1'b0}};
            count_q      <= {CW{1'b0}};
            rem_q        <= {CW{1'b0}};
            aborted_q    <= 1'b0;
            tc_err_q     <= 1'b0;
            i_q          <= 3'b001;
            inst_valid_q <= 1'b0;
            cr_data_q    <= 3'b000;
            data_out_q   <= {DW{1'b0}};
            data_oe_q    <= 1'b0;
            xfer_ack_q   <= 1'b0;
            done_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            rem_q        <= rem_d;
            aborted_q    <= aborted_d;
            tc_err_q     <= tc_err_d;
            i_q          <= i_d;
            inst_valid_q <= inst_valid_d;
            cr_data_q    <= cr_data_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            xfer_ack_q   <= xfer_ack_d;
            done_q       <= done_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign I          = i_q;
    assign inst_valid = inst_valid_q;
    assign cr_data    = cr_data_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign xfer_ack   = xfer_ack_q;
    assign done       = done_q;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign aborted    = aborted_q;
    assign tc_err     = tc_err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer: a descriptor-level model predicts
// the instruction stream, bus values, completion and sticky flags.
module tb_instruction_sequencer;

    localparam int NT = 40;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mode;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_count;
    logic        abort;
    logic        xfer_req;
    logic        xfer_ack;
    logic        tc;
    logic [2:0]  I;
    logic        inst_valid;
    logic [2:0]  cr_data;
    logic [15:0] data_out;
    logic        data_oe;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        tc_err;

    instruction_sequencer #(.DW(16), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .abort(abort), .xfer_req(xfer_req), .xfer_ack(xfer_ack), .tc(tc),
        .I(I), .inst_valid(inst_valid), .cr_data(cr_data),
        .data_out(data_out), .data_oe(data_oe),
        .busy(busy), .done(done), .aborted(aborted), .tc_err(tc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val(tag, 32'({I, inst_valid, cr_data, data_oe, xfer_ack, done, aborted, tc_err, cmd_ready, busy}),
                  32'({3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        check_val({tag, "_dout"}, 32'(data_out), 32'h0);
    endtask

    // Descriptor staged on the ports and its scenario knobs
    int  issued = 0;
    int  nxt_abort_len;
    bit  nxt_directed, nxt_flip1;

    task automatic gen_desc(input int kind);
        int r;
        nxt_abort_len = -1;
        nxt_directed  = 1'b0;
        nxt_flip1     = 1'b0;
        case (kind)
            0: begin
                cmd_mode = 3'b011; cmd_addr = 16'h1234; cmd_count = 16'd3;
                nxt_directed = 1'b1;
            end
            1: begin
                cmd_mode = 3'b110; cmd_addr = 16'h0F0F; cmd_count = 16'd0;
            end
            2: begin
                cmd_mode = 3'b010; cmd_addr = 16'h5555; cmd_count = 16'd2;
                nxt_abort_len = 4;
            end
            3: begin
                cmd_mode = 3'b001; cmd_addr = 16'hA5A5; cmd_count = 16'd2;
                nxt_flip1 = 1'b1;
            end
            default: begin
                cmd_mode  = 3'($urandom_range(0, 7));
                cmd_addr  = 16'($urandom);
                cmd_count = 16'($urandom_range(0, 5));
                if (cmd_count != 16'd0 && $urandom_range(0, 3) == 0) begin
                    r = int'($urandom_range(0, int'(cmd_count)));
                    nxt_abort_len = (r == int'(cmd_count)) ? 2 : 4 + r;
                end
            end
        endcase
        issued++;
    endtask

    function automatic logic [2:0] code_at(input int idx);
        case (idx)
            0:       return 3'b000;
            1:       return 3'b101;
            2:       return 3'b110;
            3:       return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    // Model of the transfer currently in flight
    logic [2:0]  cur_mode;
    logic [15:0] cur_addr, cur_count;
    int  cur_abort_len, exp_len, obs_len, steps, completed, cycles;
    bit  active, first_chk, new_desc_next, abort_fired, err_exp, directed, flip1;
    bit  prev_ack, prev_done, last_abort, last_wait_req, last_req_val, in_wait, want, flip, seen;
    logic [2:0] exp_code;

    initial begin
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'b000; cmd_addr = 16'h0;
        cmd_count = 16'h0; abort = 1'b0; xfer_req = 1'b0; tc = 1'b0;
        active = 0; first_chk = 0; new_desc_next = 1; abort_fired = 0;
        prev_ack = 0; prev_done = 0; last_abort = 0; last_wait_req = 0;
        completed = 0; cycles = 0; obs_len = 0; steps = 0; exp_len = 0;
        cur_abort_len = -1; err_exp = 0; directed = 0; flip1 = 0;
        #1 rst_n = 1'b0;
        #2 check_reset("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle_after_reset");

        while (completed < NT && cycles < 6000) begin
            @(negedge clk);
            cycles++;
            if (first_chk) begin
                if (cur_count == 16'd0)
                    check_val("zero_count_done", 32'({inst_valid, done}), 32'({1'b0, 1'b1}));
                else
                    check_val("first_inst", 32'({inst_valid, I}), 32'({1'b1, 3'b000}));
                check_val("flags_cleared", 32'({aborted, tc_err}), 32'h0);
                first_chk = 0;
            end
            check_val("busy_ready", 32'({busy, cmd_ready}), 32'({active, !active}));
            if (last_abort)
                check_val("abort_to_done", 32'({done, inst_valid}), 32'({1'b1, 1'b0}));
            else if (last_wait_req)
                check_val("req_to_step", 32'(xfer_ack), 32'(last_req_val));

            if (inst_valid) begin
                exp_code = code_at(obs_len);
                obs_len++;
                check_val("inst_code", 32'(I), 32'(exp_code));
                case (exp_code)
                    3'b000:  check_val("ldcr", 32'({cr_data, data_oe, xfer_ack}), 32'({cur_mode, 2'b00}));
                    3'b101:  check_val("ldar", 32'({data_oe, data_out, xfer_ack}), 32'({1'b1, cur_addr, 1'b0}));
                    3'b110:  check_val("ldwr", 32'({data_oe, data_out, xfer_ack}), 32'({1'b1, cur_count, 1'b0}));
                    3'b111: begin
                        check_val("step", 32'({xfer_ack, data_oe, prev_ack}), 32'({1'b1, 1'b0, 1'b0}));
                        steps++;
                    end
                    default: check_val("init", 32'({xfer_ack, data_oe}), 32'h0);
                endcase
            end else begin
                check_val("quiet_bus", 32'({I, xfer_ack, data_oe, data_out}), 32'({3'b001, 2'b00, 16'h0}));
            end

            if (done) begin
                check_val("done_pulse", 32'({active, prev_done}), 32'({1'b1, 1'b0}));
                check_val("stream_len", 32'(obs_len), 32'(exp_len));
                check_val("done_flags", 32'({aborted, tc_err}),
                          32'({(cur_abort_len >= 0) ? 1'b1 : 1'b0, err_exp}));
                active = 0;
                completed++;
            end
            prev_ack  = xfer_ack;
            prev_done = done;

            // Drive inputs for the next rising edge
            if (xfer_ack) begin
                want = (steps == int'(cur_count));
                flip = (flip1 && steps == 1) || (!directed && !flip1 && $urandom_range(0, 4) == 0);
                tc = flip ? !want : want;
                if (flip) err_exp = 1;
            end else begin
                tc = 1'($urandom_range(0, 1));
            end

            in_wait = busy && !inst_valid && !done;
            last_abort = 0;
            last_wait_req = 0;
            abort = 1'b0;
            if (active && !abort_fired && cur_abort_len >= 0 && obs_len == cur_abort_len &&
                ((cur_abort_len == 2) ? inst_valid : in_wait)) begin
                abort = 1'b1;
                abort_fired = 1;
                last_abort = 1;
            end else if (!busy || done) begin
                abort = ($urandom_range(0, 3) == 0);
            end
            xfer_req = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (in_wait && !last_abort) begin
                last_wait_req = 1;
                last_req_val  = xfer_req;
            end

            if (new_desc_next) begin
                new_desc_next = 0;
                if (issued < NT) begin
                    gen_desc(issued);
                    cmd_valid = 1'b1;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (cmd_valid && cmd_ready) begin
                cur_mode = cmd_mode; cur_addr = cmd_addr; cur_count = cmd_count;
                cur_abort_len = nxt_abort_len; directed = nxt_directed; flip1 = nxt_flip1;
                if (cur_abort_len >= 0) exp_len = cur_abort_len;
                else if (cmd_count == 16'd0) exp_len = 0;
                else exp_len = 4 + int'(cmd_count);
                obs_len = 0; steps = 0; err_exp = 0; abort_fired = 0;
                active = 1; first_chk = 1; new_desc_next = 1;
            end
        end
        check_val("all_transfers_done", 32'(completed), 32'(NT));

        // Reset pulsed in the middle of a transfer
        cmd_valid = 1'b0; abort = 1'b0; xfer_req = 1'b1;
        repeat (3) @(negedge clk);
        cmd_mode = 3'b101; cmd_addr = 16'hBEEF; cmd_count = 16'd5; cmd_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (!cmd_ready) cmd_valid = 1'b0;
            if (inst_valid && I == 3'b110) seen = 1;
        end
        check_val("reach_ldwr", 32'(seen), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("post_reset_idle", 32'({done, busy, inst_valid}), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
